// File: rtl/bp_prng_multi.sv
// Bytepipe-addressed bank of xoroshiro128+ generators with per-channel seeding,
// state readback, enable, free-run / step-on-read modes and burst reads.
module bp_prng_multi #(
   parameter int          N_CHAN  = 4,
   parameter logic [63:0] SEED_S0 = 64'h0123456789ABCDEF,
   parameter logic [63:0] SEED_S1 = 64'hFEDCBA9876543210
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_cg,
   input  logic [7:0] i_bp_data,
   input  logic       i_bp_valid,
   output logic       o_bp_ready,
   output logic [7:0] o_bp_data,
   output logic       o_bp_valid,
   input  logic       i_bp_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRDATA = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [6:0]          addr_q, addr_d;
   logic                isWrite_q, isWrite_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          burst_q, burst_d;
   logic [N_CHAN-1:0]   enable_q, enable_d;
   logic                mode_q, mode_d;
   logic [63:0]         s0_q [N_CHAN];
   logic [63:0]         s1_q [N_CHAN];
   logic [63:0]         s0_d [N_CHAN];
   logic [63:0]         s1_d [N_CHAN];
   logic [63:0]         resultNow [N_CHAN];
   logic [63:0]         resultNext [N_CHAN];

   logic                cmdAcc, dataAcc, respAcc;
   logic [6:0]          rdAddr;
   logic [7:0]          rdByte;
   logic [127:0]        stateWord;

   function automatic logic [127:0] xoroStep(input logic [63:0] s0, input logic [63:0] s1);
      logic [63:0] t;
      t = s0 ^ s1;
      return {{t[26:0], t[63:27]}, ({s0[39:0], s0[63:40]} ^ t ^ (t << 16))};
   endfunction

   assign cmdAcc  = i_cg && i_bp_valid && (state_q == IDLE);
   assign dataAcc = i_cg && i_bp_valid && (state_q == WRDATA);
   assign respAcc = i_cg && i_bp_ready && (state_q == RESP);

   // A seed byte for a channel takes priority over that channel stepping.
   always_comb begin
      for (int c = 0; c < N_CHAN; c++) begin
         s0_d[c] = s0_q[c];
         s1_d[c] = s1_q[c];
         if (dataAcc && (addr_q == 7'(16 + c))) begin
            {s1_d[c], s0_d[c]} = {s1_q[c][55:0], s0_q[c], i_bp_data};
         end else if (i_cg && enable_q[c] &&
                      (!mode_q || (respAcc && !isWrite_q && (addr_q == 7'(8 + c))))) begin
            {s1_d[c], s0_d[c]} = xoroStep(s0_q[c], s1_q[c]);
         end
         resultNow[c]  = s0_q[c] + s1_q[c];
         resultNext[c] = s0_d[c] + s1_d[c];
      end
   end

   // Burst refills of a result address take the post-step value so each byte is fresh.
   always_comb begin
      rdAddr    = (state_q == IDLE) ? i_bp_data[6:0] : addr_q;
      rdByte    = 8'h00;
      stateWord = '0;
      if (rdAddr == 7'h00) begin
         rdByte = burst_q;
      end else if (rdAddr == 7'h01) begin
         rdByte = 8'(enable_q);
      end else if (rdAddr == 7'h02) begin
         rdByte = {7'b0, mode_q};
      end
      for (int c = 0; c < N_CHAN; c++) begin
         if (rdAddr == 7'(8 + c)) begin
            rdByte = (state_q == RESP) ? resultNext[c][63:56] : resultNow[c][63:56];
         end
         if (rdAddr[6] && (int'(rdAddr[5:4]) == c)) begin
            stateWord = {s1_q[c], s0_q[c]};
            rdByte    = stateWord[{rdAddr[3:0], 3'b000} +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      isWrite_d = isWrite_q;
      data_d    = data_q;
      burst_d   = burst_q;
      enable_d  = enable_q;
      mode_d    = mode_q;
      unique case (state_q)
         IDLE: begin
            if (cmdAcc) begin
               addr_d    = i_bp_data[6:0];
               isWrite_d = i_bp_data[7];
               if (i_bp_data[7]) begin
                  state_d = WRDATA;
               end else begin
                  data_d  = rdByte;
                  state_d = RESP;
               end
            end
         end
         WRDATA: begin
            if (dataAcc) begin
               data_d  = rdByte;
               state_d = RESP;
               case (addr_q)
                  7'h00:   burst_d  = i_bp_data;
                  7'h01:   enable_d = i_bp_data[N_CHAN-1:0];
                  7'h02:   mode_d   = i_bp_data[0];
                  default: ;
               endcase
            end
         end
         RESP: begin
            if (respAcc) begin
               if (!isWrite_q && (addr_q != 7'h00) && (burst_q != 8'h00)) begin
                  burst_d = burst_q - 8'd1;
                  data_d  = rdByte;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_bp_ready = (state_q != RESP);
      o_bp_valid = (state_q == RESP);
   end

   assign o_bp_data = data_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         isWrite_q <= 1'b0;
         data_q    <= '0;
         burst_q   <= '0;
         enable_q  <= '1;
         mode_q    <= 1'b0;
         for (int c = 0; c < N_CHAN; c++) begin
            s0_q[c] <= SEED_S0 ^ 64'(c);
            s1_q[c] <= SEED_S1;
         end
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         isWrite_q <= isWrite_d;
         data_q    <= data_d;
         burst_q   <= burst_d;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         for (int c = 0; c < N_CHAN; c++) begin
            s0_q[c] <= s0_d[c];
            s1_q[c] <= s1_d[c];
         end
      end
   end

endmodule

// File: tb/tb_bp_prng_multi.sv
// Scoreboarded bench for bp_prng_multi: a host driver keeps a transaction-level
// model of every generator and a negedge monitor compares each accepted response.
module tb_bp_prng_multi;

   localparam int          N_CHAN  = 4;
   localparam logic [63:0] SEED_S0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] SEED_S1 = 64'hFEDCBA9876543210;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cg;
   logic [7:0] hostData;
   logic       hostValid;
   logic       devReady;
   logic [7:0] devData;
   logic       devValid;
   logic       hostReady;

   logic [63:0]       mS0 [N_CHAN];
   logic [63:0]       mS1 [N_CHAN];
   logic [7:0]        mBurst;
   logic [N_CHAN-1:0] mEn;
   logic              mMode;
   logic [7:0]        expQ [$];
   int                nChecks = 0;
   int                nFails  = 0;

   bp_prng_multi #(.N_CHAN(N_CHAN), .SEED_S0(SEED_S0), .SEED_S1(SEED_S1)) dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_cg       (cg),
      .i_bp_data  (hostData),
      .i_bp_valid (hostValid),
      .o_bp_ready (devReady),
      .o_bp_data  (devData),
      .o_bp_valid (devValid),
      .i_bp_ready (hostReady)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] rotl64(input logic [63:0] x, input int k);
      return (x << k) | (x >> (64 - k));
   endfunction

   task automatic modelStep(input int c);
      logic [63:0] t;
      t      = mS0[c] ^ mS1[c];
      mS0[c] = rotl64(mS0[c], 24) ^ t ^ (t << 16);
      mS1[c] = rotl64(t, 37);
   endtask

   function automatic logic [7:0] modelResultTop(input int c);
      logic [63:0] r;
      r = mS0[c] + mS1[c];
      return r[63:56];
   endfunction

   function automatic logic [7:0] modelByte(input logic [6:0] a);
      logic [127:0] w;
      int ch, k;
      if (a == 7'd0) return mBurst;
      if (a == 7'd1) return 8'(mEn);
      if (a == 7'd2) return {7'b0, mMode};
      if (int'(a) >= 8 && int'(a) < 8 + N_CHAN) return modelResultTop(int'(a) - 8);
      if (int'(a) >= 64) begin
         ch = (int'(a) - 64) / 16;
         k  = (int'(a) - 64) % 16;
         if (ch < N_CHAN) begin
            w = {mS1[ch], mS0[ch]};
            w = w >> (8 * k);
            return w[7:0];
         end
      end
      return 8'h00;
   endfunction

   task automatic modelReset();
      for (int c = 0; c < N_CHAN; c++) begin
         mS0[c] = SEED_S0 ^ 64'(c);
         mS1[c] = SEED_S1;
      end
      mBurst = 8'h00;
      mEn    = '1;
      mMode  = 1'b0;
   endtask

   // One enabled clock edge: advance the model as the edge will, then let it happen.
   task automatic tickEdge(input int seedCh, input int readCh);
      for (int c = 0; c < N_CHAN; c++) begin
         if (c != seedCh && mEn[c] && (!mMode || c == readCh)) modelStep(c);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tickEdge(-1, -1);
   endtask

   task automatic gatedIdle(input int n);
      cg = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      cg = 1'b1;
   endtask

   task automatic doReset();
      rstn      = 1'b0;
      hostValid = 1'b0;
      hostReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      expQ.delete();
      checkOutput("rst_valid", devValid, 0);
      checkOutput("rst_data", devData, 0);
      checkOutput("rst_ready", devReady, 1);
      rstn = 1'b1;
   endtask

   task automatic applyStimulus(input bit wr, input logic [6:0] addr, input logic [7:0] data,
                                input int maxDelay, input int holdAt);
      int nResp, rc, readCh, d;
      logic [7:0] pre;
      checkOutput("cmd_ready", devReady, 1);
      hostData  = {wr, addr};
      hostValid = 1'b1;
      if (!wr) expQ.push_back(modelByte(addr));
      tickEdge(-1, -1);
      if (wr) begin
         checkOutput("data_ready", devReady, 1);
         hostData = data;
         expQ.push_back(modelByte(addr));
         rc = (int'(addr) >= 16 && int'(addr) < 16 + N_CHAN) ? int'(addr) - 16 : -1;
         tickEdge(rc, -1);
         if (rc >= 0) begin
            {mS1[rc], mS0[rc]} = {mS1[rc][55:0], mS0[rc], data};
         end else if (addr == 7'd0) begin
            mBurst = data;
         end else if (addr == 7'd1) begin
            mEn = data[N_CHAN-1:0];
         end else if (addr == 7'd2) begin
            mMode = data[0];
         end
      end
      hostValid = 1'b0;
      nResp  = (!wr && addr != 7'd0) ? int'(mBurst) + 1 : 1;
      readCh = (!wr && int'(addr) >= 8 && int'(addr) < 8 + N_CHAN) ? int'(addr) - 8 : -1;
      for (int k = 0; k < nResp; k++) begin
         d = (k == holdAt) ? 5 : int'($urandom_range(0, maxDelay));
         repeat (d) begin
            if (expQ.size() == 0) begin
               checkOutput("hold_queue", 0, 1);
            end else begin
               checkOutput("hold_valid", devValid, 1);
               checkOutput("hold_data", devData, expQ[0]);
            end
            tickEdge(-1, -1);
         end
         hostReady = 1'b1;
         pre = modelByte(addr);
         if (k < nResp - 1) mBurst = mBurst - 8'd1;
         tickEdge(-1, readCh);
         hostReady = 1'b0;
         if (k < nResp - 1) expQ.push_back((readCh >= 0) ? modelResultTop(readCh) : pre);
      end
      checkOutput("valid_drop", devValid, 0);
   endtask

   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (rstn && cg && devValid && hostReady) begin
         if (expQ.size() == 0) begin
            checkOutput("resp_unexpected", {24'h0, devData}, 32'h100);
         end else begin
            e = expQ.pop_front();
            checkOutput("resp_data", devData, e);
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      nFails++;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      int r, sel;
      logic [6:0] a;
      cg        = 1'b1;
      hostData  = 8'h00;
      hostValid = 1'b0;
      hostReady = 1'b0;
      doReset();

      // Reset-state and address-map reads.
      applyStimulus(0, 7'h40, 0, 1, -1);
      applyStimulus(0, 7'h4F, 0, 1, -1);
      applyStimulus(0, 7'h01, 0, 1, -1);
      applyStimulus(0, 7'h7F, 0, 1, -1);
      applyStimulus(0, 7'h05, 0, 1, -1);
      applyStimulus(0, 7'h10, 0, 1, -1);
      applyStimulus(0, 7'h20, 0, 1, -1);

      // Register writes return the pre-write value.
      applyStimulus(1, 7'h01, 8'h05, 1, -1);
      applyStimulus(0, 7'h01, 0, 1, -1);
      applyStimulus(1, 7'h08, 8'hAA, 1, -1);
      applyStimulus(0, 7'h48, 0, 1, -1);

      // Step-on-read with a known seed {s1=1, s0=2} on channel 0.
      applyStimulus(1, 7'h02, 8'h01, 0, -1);
      applyStimulus(1, 7'h01, 8'h0F, 0, -1);
      for (int i = 0; i < 16; i++) applyStimulus(1, 7'h10, (i == 7) ? 8'h01 : (i == 15) ? 8'h02 : 8'h00, 0, -1);
      applyStimulus(0, 7'h08, 0, 1, -1);
      applyStimulus(0, 7'h40, 0, 1, -1);
      applyStimulus(0, 7'h48, 0, 1, -1);

      // Burst of four result bytes, then the count reads back as zero.
      applyStimulus(1, 7'h00, 8'h03, 1, -1);
      applyStimulus(0, 7'h09, 0, 2, -1);
      applyStimulus(0, 7'h00, 0, 1, -1);
      applyStimulus(0, 7'h09, 0, 1, -1);

      // Host stalls mid-burst; response must hold and the channel must not step.
      applyStimulus(1, 7'h00, 8'h02, 0, -1);
      applyStimulus(0, 7'h08, 0, 0, 1);
      applyStimulus(0, 7'h40, 0, 0, -1);

      // Free-run burst of state bytes sees a different state per byte.
      applyStimulus(1, 7'h02, 8'h00, 0, -1);
      applyStimulus(1, 7'h00, 8'h03, 0, -1);
      applyStimulus(0, 7'h53, 0, 2, -1);

      // Reset while a response is pending, then a gated interval.
      hostData  = 8'h41;
      hostValid = 1'b1;
      expQ.push_back(modelByte(7'h41));
      tickEdge(-1, -1);
      hostValid = 1'b0;
      checkOutput("resp_pending", devValid, 1);
      doReset();
      gatedIdle(10);
      checkOutput("gated_valid", devValid, 0);
      applyStimulus(0, 7'h40, 0, 0, -1);
      applyStimulus(0, 7'h4F, 0, 0, -1);
      applyStimulus(0, 7'h02, 0, 0, -1);

      for (int it = 0; it < 300; it++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 4) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
               0:       a = 7'($urandom_range(0, 2));
               1:       a = 7'(8 + $urandom_range(0, N_CHAN - 1));
               2:       a = 7'(64 + $urandom_range(0, 63));
               3:       a = 7'(16 + $urandom_range(0, 7));
               default: a = 7'($urandom_range(0, 127));
            endcase
            applyStimulus(0, a, 0, 2, -1);
         end else if (r == 5) begin
            applyStimulus(1, 7'h00, 8'($urandom_range(0, 3)), 2, -1);
         end else if (r == 6) begin
            applyStimulus(1, 7'h01, 8'($urandom_range(0, 255)), 2, -1);
         end else if (r == 7) begin
            applyStimulus(1, 7'h02, 8'($urandom_range(0, 255)), 2, -1);
         end else if (r == 8) begin
            if ($urandom_range(0, 1) == 0)
               applyStimulus(1, 7'(16 + $urandom_range(0, N_CHAN - 1)), 8'($urandom_range(0, 255)), 2, -1);
            else
               applyStimulus(1, 7'($urandom_range(3, 127)), 8'($urandom_range(0, 255)), 2, -1);
         end else begin
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 4)));
            else gatedIdle(int'($urandom_range(1, 4)));
         end
      end

      idle(3);
      checkOutput("queue_empty", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
